action_value_bandit: RTL and testbench

ACTION_VALUE_BANDIT -- requirements
Module: action_value_bandit

---
 rtl/bandit_pkg.sv | 17 +
 rtl/lfsr.sv | 27 ++
 rtl/action_value_bandit.sv | 211 +++++++++++++++++++++
 tb/tb_action_value_bandit.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bandit_pkg.sv
// Shared definitions for the action-value bandit: controller state encoding
// and the width rule for the value-update arithmetic.
package bandit_pkg;

  typedef enum logic [1:0] {
    ST_CLEARING  = 2'd0,
    ST_DECIDING  = 2'd1,
    ST_ACTUATING = 2'd2,
    ST_OBSERVING = 2'd3
  } state_e;

  // R - Q needs one bit more than the value width to be exact.
  function automatic int unsigned update_width(input int unsigned value_width);
    return value_width + 1;
  endfunction

endpackage

// File: rtl/lfsr.sv
// Fibonacci LFSR: shifts left every cycle, new bit0 = parity of (state & TAPS).
// Ports: clock, reset_n (async, active low, loads SEED), state (current value).
module lfsr #(
  parameter int unsigned        WIDTH = 8,
  parameter logic [WIDTH-1:0]   SEED  = 'hff,
  parameter logic [WIDTH-1:0]   TAPS  = 'hb1
) (
  input  logic             clock,
  input  logic             reset_n,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;

  always_comb begin
    state_d = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= SEED;
    else          state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/action_value_bandit.sv
// Epsilon-greedy action-value bandit. Keeps a table of signed Q values, picks
// the greedy action by a full table scan (ties to the lowest index) or, once
// every 2**EPSILON_SHIFT accepted actions, an LFSR-chosen action, and folds
// the observed reward in with step size 2**-ALPHA_SHIFT.
// Ports: clock/reset_n; explore_enable; reward_valid/reward_data/reward_ready
// (reward handshake); action_valid/action_data/action_value/action_explore/
// action_ready (action handshake).
module action_value_bandit
  import bandit_pkg::*;
#(
  parameter int unsigned            ACTION_WIDTH  = 8,
  parameter int unsigned            VALUE_WIDTH   = 16,
  parameter int unsigned            REWARD_WIDTH  = 8,
  parameter int unsigned            ALPHA_SHIFT   = 3,
  parameter int unsigned            EPSILON_SHIFT = 4,
  parameter int                     INIT_VALUE    = -128,
  parameter string                  INIT          = "",
  parameter logic [ACTION_WIDTH-1:0] SEED         = 'hff,
  parameter logic [ACTION_WIDTH-1:0] TAPS         = 'hb1
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           explore_enable,
  input  logic                           reward_valid,
  input  logic signed [REWARD_WIDTH-1:0] reward_data,
  output logic                           reward_ready,
  output logic                           action_valid,
  output logic [ACTION_WIDTH-1:0]        action_data,
  output logic signed [VALUE_WIDTH-1:0]  action_value,
  output logic                           action_explore,
  input  logic                           action_ready
);

  localparam int unsigned N        = 1 << ACTION_WIDTH;
  localparam int unsigned ScanW    = ACTION_WIDTH + 1;
  localparam int unsigned CntW     = (EPSILON_SHIFT > 0) ? EPSILON_SHIFT : 1;
  localparam int unsigned DiffW    = update_width(VALUE_WIDTH);
  // With a non-empty INIT the table contents come from the memory load image.
  localparam bit          Preload  = (INIT != "");
  localparam state_e      ResetSt  = Preload ? ST_DECIDING : ST_CLEARING;
  localparam logic [ScanW-1:0] ScanLast  = ScanW'(N);
  localparam logic [ScanW-1:0] ClearLast = ScanW'(N - 1);
  localparam logic [CntW-1:0]  CntExpl   = CntW'((1 << EPSILON_SHIFT) - 1);

  state_e                          state_q, state_d;
  logic [ScanW-1:0]                scan_q, scan_d;
  logic [CntW-1:0]                 cnt_q, cnt_d;
  logic                            expl_mode_q, expl_mode_d;
  logic [ACTION_WIDTH-1:0]         best_idx_q, best_idx_d;
  logic signed [VALUE_WIDTH-1:0]   best_val_q, best_val_d;
  logic [ACTION_WIDTH-1:0]         data_q, data_d;
  logic signed [VALUE_WIDTH-1:0]   value_q, value_d;
  logic                            explore_q, explore_d;
  logic                            valid_q, valid_d;
  logic                            ready_q, ready_d;

  logic                            we;
  logic [ACTION_WIDTH-1:0]         waddr;
  logic signed [VALUE_WIDTH-1:0]   wdata;
  logic [ACTION_WIDTH-1:0]         raddr;
  logic signed [VALUE_WIDTH-1:0]   rd_q;
  logic signed [VALUE_WIDTH-1:0]   mem_q [N];

  logic [ACTION_WIDTH-1:0]         lfsr_state;
  logic [ACTION_WIDTH-1:0]         cand_idx;
  logic                            take;
  logic signed [DiffW-1:0]         diff;
  logic signed [VALUE_WIDTH-1:0]   q_new;

  lfsr #(
    .WIDTH (ACTION_WIDTH),
    .SEED  (SEED),
    .TAPS  (TAPS)
  ) u_lfsr (
    .clock   (clock),
    .reset_n (reset_n),
    .state   (lfsr_state)
  );

  // Q' = Q + floor((R - Q) / 2**ALPHA_SHIFT); Q' lies between Q and R, so truncation is exact.
  assign diff  = DiffW'(reward_data) - DiffW'(value_q);
  assign q_new = VALUE_WIDTH'(DiffW'(value_q) + (diff >>> ALPHA_SHIFT));

  // Table: one write port, one registered read port.
  always_ff @(posedge clock) begin
    if (we && reset_n) mem_q[waddr] <= wdata;
    rd_q <= mem_q[raddr];
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    scan_d      = scan_q;
    cnt_d       = cnt_q;
    expl_mode_d = expl_mode_q;
    best_idx_d  = best_idx_q;
    best_val_d  = best_val_q;
    data_d      = data_q;
    value_d     = value_q;
    explore_d   = explore_q;
    valid_d     = valid_q;
    ready_d     = ready_q;
    we          = 1'b0;
    waddr       = data_q;
    wdata       = q_new;
    raddr       = scan_q[ACTION_WIDTH-1:0];
    cand_idx    = scan_q[ACTION_WIDTH-1:0] - ACTION_WIDTH'(1);
    take        = 1'b0;

    unique case (state_q)
      ST_CLEARING: begin
        we    = 1'b1;
        waddr = scan_q[ACTION_WIDTH-1:0];
        wdata = VALUE_WIDTH'(INIT_VALUE);
        if (scan_q == ClearLast) begin
          scan_d  = '0;
          state_d = ST_DECIDING;
        end else begin
          scan_d = scan_q + ScanW'(1);
        end
      end

      ST_DECIDING: begin
        if (scan_q == '0) begin
          // Exploration is decided once, on the entry cycle.
          expl_mode_d = explore_enable && (cnt_q == CntExpl);
          if (explore_enable && (cnt_q == CntExpl)) begin
            raddr  = lfsr_state;
            data_d = lfsr_state;
          end
          scan_d = ScanW'(1);
        end else if (expl_mode_q) begin
          value_d   = rd_q;
          explore_d = 1'b1;
          valid_d   = 1'b1;
          scan_d    = '0;
          state_d   = ST_ACTUATING;
        end else begin
          // rd_q holds entry scan-1; first entry always seeds the running max.
          take       = (scan_q == ScanW'(1)) || (rd_q > best_val_q);
          best_idx_d = take ? cand_idx : best_idx_q;
          best_val_d = take ? rd_q : best_val_q;
          if (scan_q == ScanLast) begin
            data_d    = best_idx_d;
            value_d   = best_val_d;
            explore_d = 1'b0;
            valid_d   = 1'b1;
            scan_d    = '0;
            state_d   = ST_ACTUATING;
          end else begin
            scan_d = scan_q + ScanW'(1);
          end
        end
      end

      ST_ACTUATING: begin
        if (action_ready) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          if (EPSILON_SHIFT > 0) cnt_d = cnt_q + CntW'(1);
          state_d = ST_OBSERVING;
        end
      end

      ST_OBSERVING: begin
        if (reward_valid) begin
          we      = 1'b1;
          ready_d = 1'b0;
          state_d = ST_DECIDING;
        end
      end

      default: state_d = ResetSt;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ResetSt;
      scan_q      <= '0;
      cnt_q       <= '0;
      expl_mode_q <= 1'b0;
      best_idx_q  <= '0;
      best_val_q  <= '0;
      data_q      <= '0;
      value_q     <= '0;
      explore_q   <= 1'b0;
      valid_q     <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      scan_q      <= scan_d;
      cnt_q       <= cnt_d;
      expl_mode_q <= expl_mode_d;
      best_idx_q  <= best_idx_d;
      best_val_q  <= best_val_d;
      data_q      <= data_d;
      value_q     <= value_d;
      explore_q   <= explore_d;
      valid_q     <= valid_d;
      ready_q     <= ready_d;
    end
  end

  assign reward_ready   = ready_q;
  assign action_valid   = valid_q;
  assign action_data    = data_q;
  assign action_value   = value_q;
  assign action_explore = explore_q;

endmodule

// File: tb/tb_action_value_bandit.sv
// Self-checking bench for action_value_bandit: a per-cycle behavioural model
// (Q table as an int array, decision timing as cycle countdowns) plus
// hand-computed expectations for the headline scenarios.
module tb_action_value_bandit;

  localparam int AW    = 8;
  localparam int VW    = 16;
  localparam int RW    = 8;
  localparam int ASH   = 3;
  localparam int ESH   = 4;
  localparam int INITV = -128;
  localparam int N     = 1 << AW;
  localparam int EPER  = 1 << ESH;
  localparam int SEEDV = 'hff;
  localparam int TAPSV = 'hb1;

  localparam int P_CLEAR = 0;
  localparam int P_DEC   = 1;
  localparam int P_ACT   = 2;
  localparam int P_OBS   = 3;

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 explore_enable = 1'b0;
  logic                 reward_valid = 1'b0;
  logic signed [RW-1:0] reward_data = '0;
  logic                 reward_ready;
  logic                 action_valid;
  logic [AW-1:0]        action_data;
  logic signed [VW-1:0] action_value;
  logic                 action_explore;
  logic                 action_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  action_value_bandit #(
    .ACTION_WIDTH  (AW),
    .VALUE_WIDTH   (VW),
    .REWARD_WIDTH  (RW),
    .ALPHA_SHIFT   (ASH),
    .EPSILON_SHIFT (ESH),
    .INIT_VALUE    (INITV),
    .INIT          (""),
    .SEED          (AW'(SEEDV)),
    .TAPS          (AW'(TAPSV))
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .explore_enable (explore_enable),
    .reward_valid   (reward_valid),
    .reward_data    (reward_data),
    .reward_ready   (reward_ready),
    .action_valid   (action_valid),
    .action_data    (action_data),
    .action_value   (action_value),
    .action_explore (action_explore),
    .action_ready   (action_ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Q + floor((R - Q) / 2**ASH), written as plain integer division.
  function automatic int q_update(input int qv, input int r);
    int d;
    int div;
    int s;
    div = 1 << ASH;
    d = r - qv;
    if (d >= 0) s = d / div;
    else        s = -((-d + div - 1) / div);
    return qv + s;
  endfunction

  function automatic int lfsr_step(input int v);
    int fb;
    fb = $countones(v & TAPSV) % 2;
    return ((v << 1) | fb) & (N - 1);
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  int q_m [N];
  int phase;
  int rem;
  bit first;
  int cnt_m;
  int lfsr_m;
  int lfsr_now;
  int exp_act;
  int exp_val;
  int exp_expl;

  always @(posedge clock) begin
    if (!reset_n) begin
      phase  = P_CLEAR;
      rem    = N;
      first  = 1'b0;
      cnt_m  = 0;
      lfsr_m = SEEDV;
      for (int i = 0; i < N; i++) q_m[i] = INITV;
    end else begin
      lfsr_now = lfsr_m;
      lfsr_m   = lfsr_step(lfsr_m);
      case (phase)
        P_CLEAR: begin
          rem--;
          if (rem == 0) begin
            phase = P_DEC;
            first = 1'b1;
          end
        end
        P_DEC: begin
          if (first) begin
            first = 1'b0;
            if (explore_enable && cnt_m == EPER - 1) begin
              exp_act  = lfsr_now;
              exp_val  = q_m[lfsr_now];
              exp_expl = 1;
              rem      = 1;
            end else begin
              exp_act = 0;
              for (int i = 1; i < N; i++)
                if (q_m[i] > q_m[exp_act]) exp_act = i;
              exp_val  = q_m[exp_act];
              exp_expl = 0;
              rem      = N;
            end
          end else begin
            rem--;
            if (rem == 0) phase = P_ACT;
          end
        end
        P_ACT: begin
          if (action_ready) begin
            cnt_m = (cnt_m + 1) % EPER;
            phase = P_OBS;
          end
        end
        default: begin
          if (reward_valid) begin
            q_m[exp_act] = q_update(q_m[exp_act], int'(reward_data));
            phase = P_DEC;
            first = 1'b1;
          end
        end
      endcase
    end
    #1;
    if (!reset_n) begin
      check("rst_action_valid", int'(action_valid), 0);
      check("rst_reward_ready", int'(reward_ready), 0);
      check("rst_action_data", int'(action_data), 0);
      check("rst_action_value", int'(action_value), 0);
      check("rst_action_explore", int'(action_explore), 0);
    end else begin
      check("model_action_valid", int'(action_valid), (phase == P_ACT) ? 1 : 0);
      check("model_reward_ready", int'(reward_ready), (phase == P_OBS) ? 1 : 0);
      if (phase == P_ACT) begin
        check("model_action_data", int'(action_data), exp_act);
        check("model_action_value", int'(action_value), exp_val);
        check("model_action_explore", int'(action_explore), exp_expl);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_valid(input bit rand_en, output int lat);
    lat = 0;
    forever begin
      @(posedge clock);
      #1;
      lat++;
      if (action_valid) break;
      if (lat > 1000) begin
        checks++;
        failures++;
        $display("FAIL wait_valid: action_valid not seen within %0d cycles", lat);
        break;
      end
      if (rand_en) begin
        @(negedge clock);
        explore_enable = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic finish_decision(input int hold, input bit pulse, input int reward,
                                 input bit rand_ready);
    int d0;
    int v0;
    int e0;
    int idle;
    d0 = int'(action_data);
    v0 = int'(action_value);
    e0 = int'(action_explore);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      reward_valid = pulse && (i == hold / 2);
      reward_data  = RW'($urandom_range(0, 255));
      @(posedge clock);
      #1;
      reward_valid = 1'b0;
      check("hold_valid", int'(action_valid), 1);
      check("hold_data", int'(action_data), d0);
      check("hold_value", int'(action_value), v0);
      check("hold_explore", int'(action_explore), e0);
      check("hold_reward_ready", int'(reward_ready), 0);
    end
    @(negedge clock);
    action_ready = 1'b1;
    @(posedge clock);
    #1;
    action_ready = 1'b0;
    idle = $urandom_range(0, 3);
    for (int i = 0; i < idle; i++) begin
      @(negedge clock);
      action_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clock);
      #1;
      action_ready = 1'b0;
    end
    check("obs_reward_ready", int'(reward_ready), 1);
    @(negedge clock);
    reward_valid = 1'b1;
    reward_data  = RW'(reward);
    @(posedge clock);
    #1;
    reward_valid = 1'b0;
  endtask

  initial begin
    int lat;
    repeat (3) @(posedge clock);
    #1;
    check("reset_valid_low", int'(action_valid), 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Cold start: clear + full scan.
    wait_valid(1'b0, lat);
    check("startup_latency", lat, 2 * N + 1);
    check("startup_data", int'(action_data), 0);
    check("startup_value", int'(action_value), -128);
    check("startup_explore", int'(action_explore), 0);

    // Held action with a stray reward pulse, then reward +80.
    finish_decision(10, 1'b1, 80, 1'b0);
    wait_valid(1'b0, lat);
    check("greedy_latency", lat, N + 1);
    check("after_80_data", int'(action_data), 0);
    check("after_80_value", int'(action_value), -102);

    finish_decision(0, 1'b0, -128, 1'b0);
    wait_valid(1'b0, lat);
    check("after_m128_data", int'(action_data), 0);
    check("after_m128_value", int'(action_value), -106);

    // Exploration enabled: decisions 15 and 31 explore.
    explore_enable = 1'b1;
    for (int d = 3; d <= 34; d++) begin
      finish_decision($urandom_range(0, 3), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 255) - 128, 1'b1);
      wait_valid(1'b0, lat);
      if (d % EPER == EPER - 1) begin
        check("explore_flag", int'(action_explore), 1);
        check("explore_latency", lat, 2);
      end else begin
        check("greedy_flag", int'(action_explore), 0);
        check("greedy_latency_loop", lat, N + 1);
      end
    end

    // Exploration disabled: never explores.
    explore_enable = 1'b0;
    for (int d = 35; d <= 50; d++) begin
      finish_decision($urandom_range(0, 2), 1'b0, $urandom_range(0, 255) - 128, 1'b1);
      wait_valid(1'b0, lat);
      check("noexplore_flag", int'(action_explore), 0);
      check("noexplore_latency", lat, N + 1);
    end

    // explore_enable toggling while deciding; model-checked.
    for (int d = 51; d <= 66; d++) begin
      explore_enable = 1'($urandom_range(0, 1));
      finish_decision($urandom_range(0, 3), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 255) - 128, 1'b1);
      wait_valid(1'b1, lat);
    end

    // Reset in OBSERVING with reward offered: no write, table re-cleared.
    explore_enable = 1'b0;
    @(negedge clock);
    action_ready = 1'b1;
    @(posedge clock);
    #1;
    action_ready = 1'b0;
    check("pre_reset_obs", int'(reward_ready), 1);
    @(negedge clock);
    reward_valid = 1'b1;
    reward_data  = RW'(127);
    reset_n      = 1'b0;
    @(posedge clock);
    #1;
    check("abort_reward_ready", int'(reward_ready), 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reward_valid = 1'b0;
    reset_n      = 1'b1;
    wait_valid(1'b0, lat);
    check("reclear_latency", lat, 2 * N + 1);
    check("reclear_data", int'(action_data), 0);
    check("reclear_value", int'(action_value), INITV);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
